// File: rtl/full_adder_pkg.sv
// ============================================================================
// Module : full_adder_pkg
// Desc   : Shared constants and result type for the full_adder slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package full_adder_pkg;

  localparam int CNT_W_DEF = 8;

  // Two-bit arithmetic result of one full-adder evaluation.
  typedef struct packed {
    logic c;
    logic s;
  } fa_res_t;

endpackage

`default_nettype wire

// File: rtl/half_adder.sv
// ============================================================================
// Module : half_adder
// Desc   : One-bit half adder, s = a ^ b, c = a & b.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module : full_adder
// Desc   : Combinational full adder built from two half adders, with
//          registered outputs, a saturating carry-event counter and an
//          optional sticky arithmetic self-check (FULL_ADDER_SELFCHECK_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module full_adder
  import full_adder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             Cin,
  output logic             Sum,
  output logic             Cout,
  output logic             Sum_q,
  output logic             Cout_q,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic    ha0_s;
  logic    ha0_c;
  logic    ha1_c;
  fa_res_t res;

  half_adder u_ha0 (
    .a (A),
    .b (B),
    .s (ha0_s),
    .c (ha0_c)
  );

  half_adder u_ha1 (
    .a (ha0_s),
    .b (Cin),
    .s (Sum),
    .c (ha1_c)
  );

  assign Cout  = ha0_c | ha1_c;
  assign res.c = Cout;
  assign res.s = Sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      Sum_q     <= 1'b0;
      Cout_q    <= 1'b0;
      carry_cnt <= '0;
    end else begin
      Sum_q  <= res.s;
      Cout_q <= res.c;
      // Saturate rather than wrap so a long carry run never reads as small.
      if (res.c && (carry_cnt != CNT_MAX)) begin
        carry_cnt <= carry_cnt + CNT_W'(1);
      end
    end
  end

`ifdef FULL_ADDER_SELFCHECK_EN
  logic [1:0] ref_sum;

  // Reference is plain addition, independent of the half-adder netlist.
  assign ref_sum = {1'b0, A} + {1'b0, B} + {1'b0, Cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (res != fa_res_t'(ref_sum)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_full_adder.sv
// ============================================================================
// Module : tb_full_adder
// Desc   : Self-checking bench for full_adder (default and CNT_W=2 instances).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_full_adder;

  logic       clk = 1'b0;
  logic       run = 1'b0;
  logic       rst = 1'b0;
  logic       A = 1'b0, B = 1'b0, Cin = 1'b0;
  logic       sum8, cout8, sq8, cq8, err8;
  logic       sum2, cout2, sq2, cq2, err2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int errors = 0;
  int checks = 0;

  // Reference model state (registered outputs and counters).
  logic m_sq, m_cq;
  int   m_c8, m_c2;

  typedef struct {
    logic a, b, cin;
    logic sum, cout;
  } vec_t;

  vec_t vecs[8];

  full_adder u_dut8 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin),
    .Sum(sum8), .Cout(cout8), .Sum_q(sq8), .Cout_q(cq8),
    .carry_cnt(cnt8), .err(err8)
  );

  full_adder #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin),
    .Sum(sum2), .Cout(cout2), .Sum_q(sq2), .Cout_q(cq2),
    .carry_cnt(cnt2), .err(err2)
  );

  always #5 if (run) clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs, check combinational outputs, clock once, check registers
  // against the arithmetic model.
  task automatic step(input logic r, input logic a, input logic b, input logic c);
    int tot;
    rst = r; A = a; B = b; Cin = c;
    tot = int'(a) + int'(b) + int'(c);
    #1;
    check("rnd_sum8",  sum8,  tot % 2);
    check("rnd_cout8", cout8, tot / 2);
    check("rnd_sum2",  sum2,  tot % 2);
    check("rnd_cout2", cout2, tot / 2);
    @(posedge clk);
    if (r) begin
      m_sq = 0; m_cq = 0; m_c8 = 0; m_c2 = 0;
    end else begin
      m_sq = logic'(tot % 2);
      m_cq = logic'(tot / 2);
      if (tot >= 2) begin
        m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
        m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
      end
    end
    #1;
    check("rnd_sq8",  sq8,  m_sq);
    check("rnd_cq8",  cq8,  m_cq);
    check("rnd_cnt8", cnt8, m_c8);
    check("rnd_sq2",  sq2,  m_sq);
    check("rnd_cq2",  cq2,  m_cq);
    check("rnd_cnt2", cnt2, m_c2);
    check("rnd_err8", err8, 0);
    check("rnd_err2", err2, 0);
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 0, 0};
    vecs[1] = '{0, 0, 1, 1, 0};
    vecs[2] = '{0, 1, 0, 1, 0};
    vecs[3] = '{0, 1, 1, 0, 1};
    vecs[4] = '{1, 0, 0, 1, 0};
    vecs[5] = '{1, 0, 1, 0, 1};
    vecs[6] = '{1, 1, 0, 0, 1};
    vecs[7] = '{1, 1, 1, 1, 1};

    // Combinational truth table with the clock stopped and rst toggled.
    for (int i = 0; i < 8; i++) begin
      A = vecs[i].a; B = vecs[i].b; Cin = vecs[i].cin;
      rst = i[0];
      #10;
      check("tt_sum",  sum8,  vecs[i].sum);
      check("tt_cout", cout8, vecs[i].cout);
      check("tt_sum2", sum2,  vecs[i].sum);
    end

    run = 1'b1;

    // Reset state.
    rst = 1'b1; A = 0; B = 0; Cin = 0;
    edge_wait();
    check("rst_sq",   sq8,  0);
    check("rst_cq",   cq8,  0);
    check("rst_cnt",  cnt8, 0);
    check("rst_err",  err8, 0);
    check("rst_cnt2", cnt2, 0);

    // One carry edge after reset.
    rst = 1'b0; A = 1; B = 1; Cin = 0;
    edge_wait();
    check("one_sq",  sq8,  0);
    check("one_cq",  cq8,  1);
    check("one_cnt", cnt8, 1);

    // Saturation of the narrow counter; wide counter keeps counting.
    rst = 1'b1;
    edge_wait();
    rst = 1'b0; A = 1; B = 1; Cin = 1;
    for (int k = 1; k <= 5; k++) begin
      edge_wait();
      check("sat_cnt2", cnt2, (k < 3) ? k : 3);
      check("sat_cnt8", cnt8, k);
      check("sat_sq",   sq2,  1);
    end

    // Reset at saturation; combinational outputs unaffected.
    rst = 1'b1; A = 1; B = 1; Cin = 0;
    #1;
    check("rsat_sum_pre",  sum2,  0);
    check("rsat_cout_pre", cout2, 1);
    edge_wait();
    check("rsat_cnt2", cnt2,  0);
    check("rsat_cnt8", cnt8,  0);
    check("rsat_sq",   sq2,   0);
    check("rsat_cq",   cq2,   0);
    check("rsat_sum",  sum2,  0);
    check("rsat_cout", cout2, 1);

    // Exhaustive clocked pass, then randomized traffic against the model.
    step(1'b1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1'b0, vecs[i].a, vecs[i].b, vecs[i].cin);
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    // Long carry run to drive the wide counter into saturation.
    for (int i = 0; i < 260; i++) step(1'b0, 1'b1, 1'b1, 1'($urandom));
    check("final_cnt8", cnt8, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter CNT_W, default 8, width of the carry-event counter (legal range 2..32).
REQ-002 clk  input  1  sole clock; all registers update on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 A  input  1  addend bit.
REQ-005 B  input  1  addend bit.
REQ-006 Cin  input  1  carry-in bit.
REQ-007 Sum  output  1  combinational sum.
REQ-008 Cout  output  1  combinational carry-out.
REQ-009 Sum_q  output  1  registered Sum.
REQ-010 Cout_q  output  1  registered Cout.
REQ-011 carry_cnt  output  CNT_W  saturating count of clock edges with Cout=1.
REQ-012 err  output  1  sticky self-check error flag.

Function
REQ-013 Sum SHALL equal A XOR B XOR Cin, purely combinational, zero latency, no clock dependence.
REQ-014 Cout SHALL equal (A AND B) OR (Cin AND (A XOR B)), purely combinational, zero latency.
REQ-015 Sum and Cout SHALL be correct for all 8 input combinations with no clock toggling and rst in any state.
REQ-016 Sum_q/Cout_q SHALL capture Sum/Cout on each rising clk edge when rst=0; latency one cycle.
REQ-017 carry_cnt SHALL increment by 1 on each rising edge with rst=0 and Cout=1, and hold otherwise.
REQ-018 carry_cnt SHALL saturate at 2^CNT_W-1; no wrap-around.
REQ-019 The 2-bit value {Cout,Sum} SHALL always equal A+B+Cin as an unsigned sum.

Reset
REQ-020 On a rising edge with rst=1: Sum_q=0, Cout_q=0, carry_cnt=0, err=0.
REQ-021 Reset SHALL take priority over counting and capture on the same edge, including mid-count or at saturation.
REQ-022 Reset SHALL NOT affect the combinational Sum and Cout outputs.

Configuration
REQ-023 Macro FULL_ADDER_SELFCHECK_EN SHALL control the self-check feature.
REQ-024 With FULL_ADDER_SELFCHECK_EN defined: each non-reset edge compares {Cout,Sum} against an independent arithmetic reference A+B+Cin; on mismatch err is set to 1 and stays 1 until reset.
REQ-025 Without FULL_ADDER_SELFCHECK_EN: err SHALL be tied to constant 0 and no checker logic synthesised; port list identical in both builds.

Structure
REQ-026 A shared package full_adder_pkg SHALL hold the CNT_W default constant and a 2-bit sum/carry result typedef.
REQ-027 One sub-module half_adder (inputs a,b; outputs s=a^b, c=a&b) SHALL be instantiated twice; Cout = OR of the two half-adder carries.
REQ-028 Counter, output registers and checker SHALL live in full_adder itself.

Verification
REQ-029 No clock; step A,B,Cin through 000..111 at 10-time-unit intervals -> Sum/Cout = 0/0,1/0,1/0,0/1,1/0,0/1,0/1,1/1.
REQ-030 rst=1 one edge, then A=1,B=1,Cin=0 for one edge -> Sum_q=0, Cout_q=1 after that edge, carry_cnt=1.
REQ-031 CNT_W=2, hold A=B=Cin=1 for 5 edges -> carry_cnt counts 1,2,3,3,3 (saturates).
REQ-032 carry_cnt=3, assert rst for one edge with A=B=1 -> carry_cnt=0, Sum_q=0, Cout_q=0; Sum=0, Cout=1 unchanged combinationally.
REQ-033 Selfcheck build, exhaustive 8 vectors over 8 clocked edges -> err remains 0; non-selfcheck build -> err constant 0.
